adc_stream_rx: RTL

- Receiver for the ADC serial bitstream (ADC_OUT qualified by CLK_S_D_OUT) on the 512 kHz weClk domain, inside WETOP's ADC path.
- Deserializes MSB-first samples and packs two samples per 32-bit word.
- Buffers words in a FWFT FIFO that the host drains through the ADC PipeOut read strobe.
- Counts samples against a programmed NSAM and reports done, overflow and occupancy.

---
 rtl/adc_stream_rx_pkg.sv | 28 ++
 rtl/adc_rx_fifo.sv | 99 +++++++++
 rtl/adc_stream_rx.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/adc_stream_rx_pkg.sv
// -----------------------------------------------------------------------------
// adc_stream_rx_pkg
// Shared definitions for the ADC serial-stream receiver: default sample width,
// word/half-word geometry, capture state encoding and the pad half-word used
// to complete the final word of an odd-length capture.
// -----------------------------------------------------------------------------
package adc_stream_rx_pkg;

    localparam int SAMPLE_W_DEFAULT = 16;
    localparam int HALF_W           = 16;
    localparam int WORD_W           = 2 * HALF_W;

    // Fills the newer-sample slot of the last word when nsam is odd.
    localparam logic [HALF_W-1:0] PAD_HALF = 16'h0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DONE_S = 2'd2
    } state_e;

    // Older sample occupies the upper half so the host reads samples in order.
    function automatic logic [WORD_W-1:0] pack_word(input logic [HALF_W-1:0] older,
                                                    input logic [HALF_W-1:0] newer);
        return {older, newer};
    endfunction

endpackage

// File: rtl/adc_rx_fifo.sv
// -----------------------------------------------------------------------------
// adc_rx_fifo
// First-word-fall-through synchronous FIFO with registered count/full/empty.
// Shared by the ADC stream path and the SPI readback path.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset (empties the FIFO)
//   push_i   in   write wdata_i; dropped when full unless a pop happens too
//   wdata_i  in   WIDTH-bit write data
//   pop_i    in   advance the head; ignored when empty
//   rdata_o  out  head word, valid whenever empty_o is low
//   empty_o  out  no words held
//   full_o   out  DEPTH words held
//   count_o  out  number of words held
// -----------------------------------------------------------------------------
module adc_rx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             empty_q;
    logic             full_q;
    logic             push_ok;
    logic             pop_ok;

    // A pop frees a slot in the same cycle, so a push at full still lands
    // when it coincides with a read.
    // NOTE: every always_comb output gets a default first so no path through
    // the block leaves it unassigned and infers a latch.
    always_comb begin
        pop_ok  = pop_i & ~empty_q;
        push_ok = push_i & (~full_q | pop_ok);
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // NOTE: the storage array is reset as well so the head reads 0 out of
    // reset instead of X; at this depth the cost of resettable storage is
    // negligible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == CNT_W'(DEPTH));
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign empty_o = empty_q;
    assign full_o  = full_q;
    assign count_o = count_q;

endmodule

// File: rtl/adc_stream_rx.sv
// -----------------------------------------------------------------------------
// adc_stream_rx
// Receives the ADC serial bitstream on the weClk domain, deserialises
// MSB-first samples, packs two samples per 32-bit word and buffers the words
// in a FWFT FIFO drained by the host PipeOut read strobe.
//
// Ports:
//   clk          in   weClk, all logic on the rising edge
//   rst          in   asynchronous active-high reset
//   start        in   one-cycle pulse arming a capture (ignored while busy)
//   nsam         in   samples to capture, latched on an accepted start
//   slp          in   ADC sleep: bit clock ignored while high
//   rst_adc      in   ADC reset: discards the partial sample
//   clk_s_d_out  in   ADC bit clock (asynchronous)
//   dout         in   ADC serial data, valid on the bit-clock rising edge
//   rd_en        in   pops the FIFO head
//   data_out     out  FIFO head {older sample, newer sample}
//   empty/full   out  FIFO status
//   fifo_count   out  words held in the FIFO
//   sample_cnt   out  samples received in the current capture
//   busy         out  capture in progress
//   done         out  one-cycle pulse at the end of a capture
//   overflow     out  sticky: a word was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module adc_stream_rx
    import adc_stream_rx_pkg::*;
#(
    parameter int SAMPLE_W   = SAMPLE_W_DEFAULT,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       nsam,
    input  logic              slp,
    input  logic              rst_adc,
    input  logic              clk_s_d_out,
    input  logic              dout,
    input  logic              rd_en,
    output logic [WORD_W-1:0] data_out,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  fifo_count,
    output logic [31:0]       sample_cnt,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int BIT_CNT_W = $clog2(SAMPLE_W);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(SAMPLE_W - 1);

    // Synchroniser chains: [0] first stage, [1] second stage, [2] edge history.
    logic [2:0]              clk_sync_q;
    logic [1:0]              dout_sync_q;

    state_e                  state_q;
    logic [31:0]             nsam_q;
    logic [31:0]             sample_cnt_q;
    logic [BIT_CNT_W-1:0]    bit_cnt_q;
    logic [SAMPLE_W-2:0]     shift_q;
    logic [HALF_W-1:0]       half_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    overflow_q;
    logic                    push_q;
    logic [WORD_W-1:0]       push_data_q;

    logic                    bit_strobe;
    logic                    bit_d;
    logic [SAMPLE_W-1:0]     sample_d;
    logic [HALF_W-1:0]       sample_ext_d;
    logic [31:0]             sample_cnt_d;
    logic                    fifo_full;

    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q  <= '0;
            dout_sync_q <= '0;
        end else begin
            clk_sync_q  <= {clk_sync_q[1:0], clk_s_d_out};
            dout_sync_q <= {dout_sync_q[0], dout};
        end
    end

    // The data bit is taken from the same synchroniser depth as the clock
    // stage that flags the edge, so it is the value present at that edge.
    assign bit_strobe   = clk_sync_q[1] & ~clk_sync_q[2];
    assign bit_d        = dout_sync_q[1];
    assign sample_d     = {shift_q, bit_d};
    assign sample_ext_d = HALF_W'(sample_d);
    assign sample_cnt_d = sample_cnt_q + 32'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            nsam_q       <= '0;
            sample_cnt_q <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            half_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            push_q       <= 1'b0;
            push_data_q  <= '0;
        end else begin
            push_q <= 1'b0;
            done_q <= 1'b0;

            // The word presented last cycle is lost when the FIFO is full and
            // no read frees a slot.
            if (push_q && fifo_full && !rd_en) begin
                overflow_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        nsam_q       <= nsam;
                        sample_cnt_q <= '0;
                        overflow_q   <= 1'b0;
                        bit_cnt_q    <= '0;
                        shift_q      <= '0;
                        if (nsam != 32'd0) begin
                            state_q <= SHIFT;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= DONE_S;
                            done_q  <= 1'b1;
                        end
                    end
                end

                SHIFT: begin
                    if (rst_adc) begin
                        // Only the partial sample is discarded; completed
                        // samples and the pending half-word survive.
                        bit_cnt_q <= '0;
                        shift_q   <= '0;
                    end else if (bit_strobe && !slp) begin
                        shift_q <= sample_d[SAMPLE_W-2:0];
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_q    <= '0;
                            sample_cnt_q <= sample_cnt_d;
                            if (!sample_cnt_q[0]) begin
                                half_q <= sample_ext_d;
                            end else begin
                                push_q      <= 1'b1;
                                push_data_q <= pack_word(half_q, sample_ext_d);
                            end
                            if (sample_cnt_d == nsam_q) begin
                                // Odd count: the last sample would otherwise
                                // sit unpaired in the half-word register.
                                if (nsam_q[0]) begin
                                    push_q      <= 1'b1;
                                    push_data_q <= pack_word(sample_ext_d, PAD_HALF);
                                end
                                state_q <= DONE_S;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
                        end
                    end
                end

                DONE_S: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    adc_rx_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_q),
        .wdata_i (push_data_q),
        .pop_i   (rd_en),
        .rdata_o (data_out),
        .empty_o (empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    assign full       = fifo_full;
    assign sample_cnt = sample_cnt_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = overflow_q;

endmodule
